// File: rtl/alu_muldiv_seq.sv
// Multi-cycle RV32M MUL / DIVU / REMU sequencer that borrows the shared combinational ALU
// one operation per cycle (shift-and-add multiply, restoring divide).
module alu_muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_y
);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // acc holds the product (MUL) or the partial remainder (DIV);
  // mcand doubles as the divisor, mplier as the dividend/quotient shifter.
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] result_q, result_d;

  logic [32:0] rem_sh_s;
  logic        ge_s;
  logic        last_s;

  assign rem_sh_s = {acc_q, mplier_q[31]};
  assign ge_s     = (rem_sh_s >= {1'b0, mcand_q});
  assign last_s   = (cnt_q == 5'd31);
  assign result   = result_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 32'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      op_q     <= 2'b00;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MUL:  state_d = S_MUL;
            OP_DIVU: state_d = (rs2 == 32'd0) ? S_DONE : S_DIV;
            OP_REMU: state_d = (rs2 == 32'd0) ? S_DONE : S_DIV;
            default: state_d = S_DONE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DIV: begin
        if (last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DIV;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values; the ALU result feeds back within the same cycle.
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    op_d     = op_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          cnt_d = 5'd0;
          case (op)
            OP_MUL: begin
              acc_d    = 32'd0;
              mcand_d  = rs1;
              mplier_d = rs2;
            end
            OP_DIVU: begin
              if (rs2 == 32'd0) begin
                result_d = 32'hFFFF_FFFF;
              end else begin
                acc_d    = 32'd0;
                mplier_d = rs1;
                mcand_d  = rs2;
              end
            end
            OP_REMU: begin
              if (rs2 == 32'd0) begin
                result_d = rs1;
              end else begin
                acc_d    = 32'd0;
                mplier_d = rs1;
                mcand_d  = rs2;
              end
            end
            default: result_d = 32'd0;
          endcase
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_MUL: begin
        if (mplier_q[0]) begin
          acc_d = alu_y;
        end else begin
          acc_d = acc_q;
        end
        mcand_d  = {mcand_q[30:0], 1'b0};
        mplier_d = {1'b0, mplier_q[31:1]};
        cnt_d    = cnt_q + 5'd1;
        if (last_s) begin
          result_d = acc_d;
        end else begin
          result_d = result_q;
        end
      end
      S_DIV: begin
        // alu_y = rem_sh - dvs, which fits in 32 bits whenever ge holds.
        if (ge_s) begin
          acc_d = alu_y;
        end else begin
          acc_d = rem_sh_s[31:0];
        end
        mplier_d = {mplier_q[30:0], ge_s};
        cnt_d    = cnt_q + 5'd1;
        if (last_s) begin
          result_d = (op_q == OP_REMU) ? acc_d : mplier_d;
        end else begin
          result_d = result_q;
        end
      end
      S_DONE:  cnt_d = cnt_q;
      default: cnt_d = cnt_q;
    endcase
  end

  // Status flags and ALU operand/opcode drive.
  always_comb begin
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE);
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    alu_op = ALU_ADD;
    case (state_q)
      S_MUL: begin
        alu_a  = acc_q;
        alu_b  = mcand_q;
        alu_op = ALU_ADD;
      end
      S_DIV: begin
        alu_a  = rem_sh_s[31:0];
        alu_b  = mcand_q;
        alu_op = ALU_SUB;
      end
      default: begin
        alu_a  = 32'd0;
        alu_b  = 32'd0;
        alu_op = ALU_ADD;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: arithmetic-level reference model checked every cycle,
// directed literal cases and a randomized phase with stray starts and resets.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_y;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .busy(busy), .done(done), .result(result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y)
  );

  // The shared ALU: 0 = add, 1 = sub.
  assign alu_y = (alu_op == 4'd0) ? (alu_a + alu_b) : (alu_a - alu_b);

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      2'd0:    return a * b;
      2'd1:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      2'd2:    return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] b);
    if (o == 2'd3 || (o != 2'd0 && b == 32'd0)) return 1;
    return 33;
  endfunction

  // Model: k counts cycles since the accepted start (0 = idle).
  int          k      = 0;
  int          lat    = 0;
  logic [1:0]  m_op   = 2'd0;
  logic [31:0] m_a    = 32'd0;
  logic [31:0] m_b    = 32'd0;
  logic [31:0] m_pend = 32'd0;
  logic [31:0] m_res  = 32'd0;

  always @(posedge clk) begin
    if (rst) begin
      k     <= 0;
      m_res <= 32'd0;
    end else if (k == 0) begin
      if (start) begin
        m_op   <= op;
        m_a    <= rs1;
        m_b    <= rs2;
        lat    <= ref_lat(op, rs2);
        m_pend <= ref_res(op, rs1, rs2);
        k      <= 1;
        if (ref_lat(op, rs2) == 1) m_res <= ref_res(op, rs1, rs2);
      end
    end else if (k >= lat) begin
      k <= 0;
    end else begin
      k <= k + 1;
      if (k + 1 == lat) m_res <= m_pend;
    end
  end

  // Expected ALU drive for iteration j: partial product / shifted partial remainder.
  int          j_s;
  logic [63:0] t_s;
  logic [31:0] e_a, e_b;
  logic [3:0]  e_op;
  always_comb begin
    j_s  = 0;
    t_s  = 64'd0;
    e_a  = 32'd0;
    e_b  = 32'd0;
    e_op = 4'd0;
    if (k >= 1 && k <= 32 && lat == 33) begin
      j_s = k - 1;
      if (m_op == 2'd0) begin
        t_s  = {32'd0, m_a} * ({32'd0, m_b} & ((64'd1 << j_s) - 64'd1));
        e_a  = t_s[31:0];
        t_s  = {32'd0, m_a} << j_s;
        e_b  = t_s[31:0];
        e_op = 4'd0;
      end else begin
        t_s  = ((({32'd0, m_a} >> (32 - j_s)) % {32'd0, m_b}) * 64'd2)
               + (({32'd0, m_a} >> (31 - j_s)) & 64'd1);
        e_a  = t_s[31:0];
        e_b  = m_b;
        e_op = 4'd1;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy",   {31'd0, busy},   {31'd0, (k != 0)});
    chk("done",   {31'd0, done},   {31'd0, (k != 0 && k == lat)});
    chk("result", result,          m_res);
    chk("alu_op", {28'd0, alu_op}, {28'd0, e_op});
    chk("alu_a",  alu_a,           e_a);
    chk("alu_b",  alu_b,           e_b);
  end

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int elat,
                        input bit poke);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    @(posedge clk); #2;
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk); #2;
    start = 1'b0; op = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        n   = c;
      end else if (poke && c == 10) begin
        start = 1'b1; op = 2'd1; rs1 = $urandom; rs2 = 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    chk({nm, " done seen"}, {31'd0, got}, 32'd1);
    chk({nm, " result"}, result, exp);
    chk({nm, " latency"}, 32'(n), 32'(elat));
    if (poke) begin
      start = 1'b1; op = 2'd0; rs1 = 32'd9; rs2 = 32'd9;
      @(posedge clk); #2;
      start = 1'b0;
      @(negedge clk);
      chk({nm, " held"}, result, exp);
      chk({nm, " idle after"}, {31'd0, busy}, 32'd0);
    end else begin
      @(posedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'd0; rs1 = 32'd0; rs2 = 32'd0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset busy",   {31'd0, busy},   32'd0);
    chk("reset done",   {31'd0, done},   32'd0);
    chk("reset result", result,          32'd0);
    chk("reset alu_a",  alu_a,           32'd0);
    chk("reset alu_b",  alu_b,           32'd0);
    chk("reset alu_op", {28'd0, alu_op}, 32'd0);

    run_op("mul 7x6",      2'd0, 32'd7,         32'd6,         32'd42,        33, 1'b0);
    run_op("mul max",      2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         33, 1'b0);
    run_op("mul ovf",      2'd0, 32'h8000_0000, 32'd2,         32'd0,         33, 1'b0);
    run_op("divu 100/7",   2'd1, 32'd100,       32'd7,         32'd14,        33, 1'b0);
    run_op("remu 100/7",   2'd2, 32'd100,       32'd7,         32'd2,         33, 1'b0);
    run_op("divu max/1",   2'd1, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33, 1'b0);
    run_op("remu 5/9",     2'd2, 32'd5,         32'd9,         32'd5,         33, 1'b0);
    run_op("divu x/0",     2'd1, 32'd77,        32'd0,         32'hFFFF_FFFF, 1,  1'b0);
    run_op("remu 1234/0",  2'd2, 32'h1234,      32'd0,         32'h1234,      1,  1'b0);
    run_op("op11",         2'd3, 32'd5,         32'd6,         32'd0,         1,  1'b0);
    run_op("mul stray st", 2'd0, 32'd12345,     32'd678,       32'd8369910,   33, 1'b1);

    // Reset in the middle of a divide (iteration 10).
    @(posedge clk); #2;
    start = 1'b1; op = 2'd1; rs1 = 32'd1000000; rs2 = 32'd3;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("abort busy",   {31'd0, busy},   32'd0);
    chk("abort done",   {31'd0, done},   32'd0);
    chk("abort result", result,          32'd0);
    chk("abort alu_a",  alu_a,           32'd0);
    chk("abort alu_b",  alu_b,           32'd0);
    chk("abort alu_op", {28'd0, alu_op}, 32'd0);
    run_op("mul 3x5", 2'd0, 32'd3, 32'd5, 32'd15, 33, 1'b0);

    // Random traffic: starts at any time, occasional resets and zero divisors.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #2;
      rst   = ($urandom_range(0, 399) == 0);
      start = ($urandom_range(0, 2) == 0);
      op    = 2'($urandom_range(0, 3));
      rs1   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      if ($urandom_range(0, 7) == 0) rs2 = 32'd0;
      else if ($urandom_range(0, 3) == 0) rs2 = 32'($urandom_range(1, 255));
      else rs2 = $urandom;
    end
    @(posedge clk); #2;
    rst = 1'b0; start = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
